// File: rtl/zx_key_matrix_rx_if.sv
// rtl/zx_key_matrix_rx_if.sv - serial-link pins and bus-side signals of the key matrix receiver
interface zx_key_matrix_rx_if #(
    parameter int ROWS = 8,
    parameter int COLS = 5
);
    logic            dat;
    logic            sk;
    logic            stb;
    logic [ROWS-1:0] a;
    logic [COLS-1:0] kd;
    logic            nmi_oe;
    logic            rst_oe;
    logic            bsrq_oe;
    logic            frame_err;

    modport master (
        output dat, sk, stb, a,
        input  kd, nmi_oe, rst_oe, bsrq_oe, frame_err
    );

    modport slave (
        input  dat, sk, stb, a,
        output kd, nmi_oe, rst_oe, bsrq_oe, frame_err
    );
endinterface

// File: rtl/zx_key_matrix_rx.sv
// rtl/zx_key_matrix_rx.sv - serial crosspoint receiver holding the ZX keyboard matrix and special keys
module zx_key_matrix_rx #(
    parameter int AY_W      = 3,
    parameter int AX_W      = 4,
    parameter int ROWS      = 8,
    parameter int COLS      = 5,
    parameter int SPECIAL_X = 8,
    parameter int RST_MIN   = 64,
    parameter int TIMEOUT   = 2**20
) (
    input  logic              clk,
    input  logic              rst,
    zx_key_matrix_rx_if.slave bus
);
    localparam int N  = AY_W + AX_W;
    localparam int BW = $clog2(N + 2);
    localparam int SW = $clog2(RST_MIN + 1);
    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [BW-1:0] BC_FULL = BW'(N);
    localparam logic [BW-1:0] BC_SAT  = BW'(N + 1);
    localparam logic [TW-1:0] TO_MAX  = TW'(TIMEOUT);
    localparam logic [SW-1:0] ST_LOAD = SW'(RST_MIN);

    // {dat, sk, stb}
    logic [2:0]      s1, s2;
    logic            sk_q, stb_q;
    logic            dat_s, sk_rise, stb_rise;
    logic [N-1:0]    sr;
    logic [BW-1:0]   bitcnt;
    logic [AY_W-1:0] y;
    logic [AX_W-1:0] x;
    logic            frame_ok, spec;
    logic [TW-1:0]   tcnt;
    logic            timeout_hit;
    logic [COLS-1:0] key [ROWS];
    logic            magic_p, reset_p, pause_p, reset_nx;
    logic [SW-1:0]   stretch;
    logic            frame_err_q;
    logic [COLS-1:0] kd_v;

    assign dat_s    = s2[2];
    assign sk_rise  = s2[1] & ~sk_q;
    assign stb_rise = s2[0] & ~stb_q;
    assign y        = sr[N-1:AX_W];
    assign x        = sr[AX_W-1:0];
    assign frame_ok = stb_rise && (bitcnt == BC_FULL);
    assign spec     = frame_ok && (x == AX_W'(SPECIAL_X));

    assign timeout_hit = (TIMEOUT != 0) && !stb_rise && (tcnt == TO_MAX - TW'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1    <= '0;
            s2    <= '0;
            sk_q  <= 1'b0;
            stb_q <= 1'b0;
        end else begin
            s1    <= {bus.dat, bus.sk, bus.stb};
            s2    <= s1;
            sk_q  <= s2[1];
            stb_q <= s2[0];
        end
    end

    // A coincident SK rise shifts after the commit has sampled SR and seeds the next frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr     <= '0;
            bitcnt <= '0;
        end else begin
            if (sk_rise)
                sr <= {sr[N-2:0], dat_s};
            if (stb_rise)
                bitcnt <= sk_rise ? BW'(1) : '0;
            else if (sk_rise && bitcnt != BC_SAT)
                bitcnt <= bitcnt + BW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            tcnt <= '0;
        else if (stb_rise)
            tcnt <= '0;
        else if (TIMEOUT != 0 && tcnt != TO_MAX)
            tcnt <= tcnt + TW'(1);
    end

    always_comb begin
        reset_nx = reset_p;
        if (timeout_hit)
            reset_nx = 1'b0;
        else if (spec && y == AY_W'(6))
            reset_nx = ~dat_s;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < ROWS; r++)
                key[r] <= '1;
            magic_p     <= 1'b0;
            reset_p     <= 1'b0;
            pause_p     <= 1'b0;
            stretch     <= '0;
            frame_err_q <= 1'b0;
        end else begin
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++)
                    if (timeout_hit)
                        key[r][c] <= 1'b1;
                    else if (frame_ok && x == AX_W'(r) && y == AY_W'(c))
                        key[r][c] <= dat_s;
            if (timeout_hit)
                magic_p <= 1'b0;
            else if (spec && y == AY_W'(5))
                magic_p <= ~dat_s;
            if (timeout_hit)
                pause_p <= 1'b0;
            else if (spec && y == AY_W'(7))
                pause_p <= ~dat_s;
            reset_p <= reset_nx;
            // Stretch window counts from each new press, so a re-press never opens a gap.
            if (reset_nx && !reset_p)
                stretch <= ST_LOAD;
            else if (stretch != '0)
                stretch <= stretch - SW'(1);
            frame_err_q <= stb_rise && (bitcnt != BC_FULL);
        end
    end

    always_comb begin
        kd_v = '1;
        for (int r = 0; r < ROWS; r++)
            if (!bus.a[r])
                kd_v = kd_v & key[r];
    end

    assign bus.kd        = kd_v;
    assign bus.nmi_oe    = magic_p;
    assign bus.bsrq_oe   = pause_p;
    assign bus.rst_oe    = reset_p | (stretch != '0);
    assign bus.frame_err = frame_err_q;
endmodule

// File: tb/tb_zx_key_matrix_rx.sv
// tb/tb_zx_key_matrix_rx.sv - directed self-checking bench for zx_key_matrix_rx
module tb_zx_key_matrix_rx;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    zx_key_matrix_rx_if #(.ROWS(8), .COLS(5)) bus ();

    zx_key_matrix_rx #(.TIMEOUT(100)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic shift_bit(input logic b);
        bus.dat = b;
        bus.sk  = 1'b0;
        wait_n(3);
        bus.sk  = 1'b1;
        wait_n(3);
    endtask

    task automatic shift_frame(input logic [2:0] y, input logic [3:0] x);
        logic [6:0] f;
        f = {y, x};
        for (int i = 6; i >= 0; i--)
            shift_bit(f[i]);
    endtask

    task automatic strobe(input logic state);
        bus.sk  = 1'b0;
        bus.dat = state;
        wait_n(3);
        bus.stb = 1'b1;
        wait_n(3);
        bus.stb = 1'b0;
        wait_n(3);
    endtask

    task automatic send_frame(input logic [2:0] y, input logic [3:0] x, input logic state);
        shift_frame(y, x);
        strobe(state);
    endtask

    task automatic check_kd(input string name, input logic [7:0] a, input logic [4:0] exp);
        bus.a = a;
        #1;
        checks++;
        if (bus.kd !== exp) begin
            failures++;
            $display("FAIL %s: kd=%b expected %b (a=%h)", name, bus.kd, exp, a);
        end
    endtask

    task automatic test_reset;
        bus.dat = 1'b0; bus.sk = 1'b0; bus.stb = 1'b0; bus.a = 8'hFF;
        rst = 1'b1;
        wait_n(3);
        check_kd("reset_fe", 8'hFE, 5'b11111);
        check_kd("reset_7f", 8'h7F, 5'b11111);
        checks++;
        if ({bus.nmi_oe, bus.rst_oe, bus.bsrq_oe, bus.frame_err} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_oe: got %b expected 0000",
                     {bus.nmi_oe, bus.rst_oe, bus.bsrq_oe, bus.frame_err});
        end
        rst = 1'b0;
        wait_n(2);
    endtask

    task automatic test_rows;
        send_frame(3'd0, 4'd0, 1'b0);
        send_frame(3'd1, 4'd1, 1'b0);
        send_frame(3'd2, 4'd2, 1'b0);
        check_kd("row0", 8'hFE, 5'b11110);
        check_kd("row1", 8'hFD, 5'b11101);
        check_kd("row2", 8'hFB, 5'b11011);
    endtask

    task automatic test_columns;
        logic [4:0] st;
        st = 5'b10101;
        for (int c = 0; c < 5; c++)
            send_frame(3'(c), 4'd3, st[c]);
        check_kd("row3_alt", 8'hF7, 5'b10101);
        send_frame(3'd2, 4'd6, 1'b0);
        send_frame(3'd1, 4'd7, 1'b0);
        check_kd("rows67_and", 8'h3F, 5'b11001);
        check_kd("all_rows", 8'h00, 5'b10000);
        check_kd("no_rows", 8'hFF, 5'b11111);
    endtask

    task automatic test_magic;
        shift_frame(3'd5, 4'd8);
        bus.sk = 1'b0; bus.dat = 1'b0;
        wait_n(3);
        bus.stb = 1'b1;
        wait_n(2);
        checks++;
        if (bus.nmi_oe !== 1'b0) begin
            failures++;
            $display("FAIL nmi_early: got %b expected 0", bus.nmi_oe);
        end
        wait_n(1);
        checks++;
        if (bus.nmi_oe !== 1'b1) begin
            failures++;
            $display("FAIL nmi_press: got %b expected 1", bus.nmi_oe);
        end
        bus.stb = 1'b0;
        wait_n(3);
        send_frame(3'd5, 4'd8, 1'b1);
        checks++;
        if (bus.nmi_oe !== 1'b0) begin
            failures++;
            $display("FAIL nmi_release: got %b expected 0", bus.nmi_oe);
        end
    endtask

    task automatic test_reset_stretch;
        int high_cnt = 0;
        int waited = 0;
        fork
            begin
                send_frame(3'd6, 4'd8, 1'b0);
                wait_n(10);
                send_frame(3'd6, 4'd8, 1'b1);
            end
            begin
                while (bus.rst_oe !== 1'b1 && waited < 200) begin
                    wait_n(1);
                    waited++;
                end
                while (bus.rst_oe === 1'b1 && high_cnt < 300) begin
                    high_cnt++;
                    wait_n(1);
                end
            end
        join
        checks++;
        if (high_cnt != 64) begin
            failures++;
            $display("FAIL rst_stretch: high for %0d cycles expected 64", high_cnt);
        end
        checks++;
        if (bus.bsrq_oe !== 1'b0) begin
            failures++;
            $display("FAIL bsrq_idle: got %b expected 0", bus.bsrq_oe);
        end
    endtask

    task automatic test_frame_err;
        int pulses = 0;
        for (int i = 0; i < 6; i++)
            shift_bit((i == 3) ? 1'b1 : 1'b0);
        bus.sk = 1'b0; bus.dat = 1'b0;
        wait_n(3);
        bus.stb = 1'b1;
        for (int i = 0; i < 8; i++) begin
            wait_n(1);
            if (bus.frame_err === 1'b1)
                pulses++;
        end
        bus.stb = 1'b0;
        wait_n(3);
        checks++;
        if (pulses != 1) begin
            failures++;
            $display("FAIL frame_err_pulse: %0d cycles high expected 1", pulses);
        end
        check_kd("frame_err_row4", 8'hEF, 5'b11111);
        check_kd("frame_err_all", 8'h00, 5'b10000);
    endtask

    task automatic test_reset_midframe;
        for (int i = 0; i < 4; i++)
            shift_bit(1'b1);
        bus.sk = 1'b0;
        rst = 1'b1;
        wait_n(1);
        check_kd("midrst_clear", 8'h00, 5'b11111);
        rst = 1'b0;
        wait_n(2);
        send_frame(3'd3, 4'd4, 1'b0);
        check_kd("midrst_frame", 8'hEF, 5'b10111);
    endtask

    task automatic test_back_to_back;
        logic [6:0] f;
        shift_frame(3'd4, 4'd5);
        bus.sk = 1'b0; bus.dat = 1'b0;
        wait_n(3);
        bus.sk = 1'b1; bus.stb = 1'b1;
        wait_n(3);
        bus.sk = 1'b0; bus.stb = 1'b0;
        wait_n(3);
        check_kd("simul_commit", 8'hDF, 5'b01111);
        f = {3'd3, 4'd5};
        for (int i = 5; i >= 0; i--)
            shift_bit(f[i]);
        strobe(1'b0);
        check_kd("simul_next", 8'hDF, 5'b00111);
    endtask

    task automatic test_timeout;
        send_frame(3'd1, 4'd7, 1'b0);
        check_kd("to_pressed", 8'h7F, 5'b11101);
        wait_n(90);
        check_kd("to_before", 8'h7F, 5'b11101);
        wait_n(10);
        check_kd("to_released", 8'h7F, 5'b11111);
        check_kd("to_all", 8'h00, 5'b11111);
    endtask

    initial begin
        test_reset();
        test_rows();
        test_columns();
        test_magic();
        test_reset_stretch();
        test_frame_err();
        test_reset_midframe();
        test_back_to_back();
        test_timeout();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
